// File: rtl/core_sequencer_pkg.sv
// Shared types and helpers for the multi-cycle core sequencer and its load/store aligner.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH_REQUEST  = 3'd0,
        FETCH_WAIT     = 3'd1,
        EXECUTE        = 3'd2,
        MEMORY_REQUEST = 3'd3,
        MEMORY_WAIT    = 3'd4,
        WRITEBACK      = 3'd5,
        HALTED         = 3'd6
    } sequencer_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE                = 2'd0,
        TRAP_ILLEGAL_INSTRUCTION = 2'd1,
        TRAP_MISALIGNED_ACCESS   = 2'd2,
        TRAP_MEMORY_TIMEOUT      = 2'd3
    } trap_cause_t;

    // Encoding 3 is not a legal size and is handled as a word access.
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'd0,
        SIZE_HALFWORD = 2'd1,
        SIZE_WORD     = 2'd2
    } memory_size_t;

    // The memory port only ever sees word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] address);
        return address & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/core_sequencer_load_store_aligner.sv
// Combinational lane logic: store byte enables and lane replication, load lane
// extraction with sign/zero extension, and the misaligned-access flag.
module load_store_aligner
    import core_sequencer_pkg::*;
(
    input  memory_size_t size,
    input  logic [1:0]   offset,
    input  logic         load_unsigned,
    input  logic [31:0]  store_data,
    input  logic [31:0]  read_data,
    output logic [3:0]   byte_enable,
    output logic [31:0]  write_data,
    output logic [31:0]  load_value,
    output logic         misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = read_data[{offset, 3'b000} +: 8];
    assign half_lane = offset[1] ? read_data[31:16] : read_data[15:0];

    // Select lanes and extension according to access size.
    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves a latch behind.
        byte_enable = 4'b1111;
        write_data  = store_data;
        load_value  = read_data;
        misaligned  = 1'b0;
        case (size)
            SIZE_BYTE: begin
                byte_enable = 4'b0001 << offset;
                write_data  = {4{store_data[7:0]}};
                load_value  = {{24{~load_unsigned & byte_lane[7]}}, byte_lane};
            end
            SIZE_HALFWORD: begin
                byte_enable = 4'b0011 << offset;
                write_data  = {2{store_data[15:0]}};
                load_value  = {{16{~load_unsigned & half_lane[15]}}, half_lane};
                misaligned  = offset[0];
            end
            default: begin
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the tiny RISC-V core: shares one memory port between
// fetch and load/store, gates register-file and PC writes, and traps on illegal
// instructions, misaligned accesses and memory timeouts.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run_enable,
    input  logic [31:0] program_counter,
    input  logic        instruction_valid,
    input  logic        decoded_register_write_enable,
    input  logic        decoded_memory_read,
    input  logic        decoded_memory_write,
    input  logic [1:0]  memory_size,
    input  logic        load_unsigned,
    input  logic [31:0] data_address,
    input  logic [31:0] store_data,
    output logic        memory_request_valid,
    input  logic        memory_request_ready,
    output logic [31:0] memory_address,
    output logic        memory_write_enable,
    output logic [3:0]  memory_byte_enable,
    output logic [31:0] memory_write_data,
    input  logic        memory_response_valid,
    input  logic [31:0] memory_read_data,
    output logic [31:0] instruction,
    output logic [31:0] load_data,
    output logic        register_write_strobe,
    output logic        pc_update_enable,
    output logic        halted,
    output logic [1:0]  trap_cause
);

    localparam int unsigned COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

    sequencer_state_t       state;
    trap_cause_t            trap_q;
    logic                   fetch_pending;
    logic [31:0]            address_q;
    memory_size_t           size_q;
    logic [1:0]             offset_q;
    logic                   unsigned_q;
    logic [COUNT_WIDTH-1:0] timeout_count;

    logic                   in_execute;
    logic                   memory_access;
    logic                   counting;
    logic                   timeout_hit;
    memory_size_t           align_size;
    logic [1:0]             align_offset;
    logic                   align_unsigned;
    logic [3:0]             align_byte_enable;
    logic [31:0]            align_write_data;
    logic [31:0]            align_load_value;
    logic                   align_misaligned;

    assign trap_cause    = trap_q;
    assign in_execute    = (state == EXECUTE);
    assign memory_access = decoded_memory_read | decoded_memory_write;

    // The decoder drives the aligner during EXECUTE; afterwards the latched access shape does.
    assign align_size     = in_execute ? memory_size_t'(memory_size) : size_q;
    assign align_offset   = in_execute ? data_address[1:0] : offset_q;
    assign align_unsigned = in_execute ? load_unsigned : unsigned_q;

    assign counting = ((state == FETCH_REQUEST) && memory_request_valid) ||
                      (state == FETCH_WAIT) || (state == MEMORY_REQUEST) ||
                      (state == MEMORY_WAIT);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timeout_count == TIMEOUT_LIMIT);

    load_store_aligner u_aligner (
        .size          (align_size),
        .offset        (align_offset),
        .load_unsigned (align_unsigned),
        .store_data    (store_data),
        .read_data     (memory_read_data),
        .byte_enable   (align_byte_enable),
        .write_data    (align_write_data),
        .load_value    (align_load_value),
        .misaligned    (align_misaligned)
    );

    // Request valid, fetch address and commit strobes decoded from the current state.
    always_comb begin
        memory_request_valid  = 1'b0;
        memory_address        = address_q;
        register_write_strobe = 1'b0;
        pc_update_enable      = 1'b0;
        case (state)
            FETCH_REQUEST: begin
                // A fetch already presented stays up even if run_enable drops.
                memory_request_valid = run_enable | fetch_pending;
                if (!fetch_pending) begin
                    memory_address = word_align(program_counter);
                end
            end
            EXECUTE: begin
                if (instruction_valid && !memory_access) begin
                    register_write_strobe = decoded_register_write_enable;
                    pc_update_enable      = 1'b1;
                end
            end
            MEMORY_REQUEST: memory_request_valid = 1'b1;
            MEMORY_WAIT: begin
                if (memory_response_valid && !timeout_hit && memory_write_enable) begin
                    pc_update_enable = 1'b1;
                end
            end
            WRITEBACK: begin
                register_write_strobe = 1'b1;
                pc_update_enable      = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, request registers, trap status and timeout counter.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state               <= FETCH_REQUEST;
            trap_q              <= TRAP_NONE;
            fetch_pending       <= 1'b0;
            address_q           <= '0;
            size_q              <= SIZE_BYTE;
            offset_q            <= '0;
            unsigned_q          <= 1'b0;
            timeout_count       <= '0;
            memory_write_enable <= 1'b0;
            memory_byte_enable  <= '0;
            memory_write_data   <= '0;
            instruction         <= '0;
            load_data           <= '0;
            halted              <= 1'b0;
        end else if (counting && timeout_hit) begin
            // Timeout wins over any handshake or response in the same cycle.
            state               <= HALTED;
            trap_q              <= TRAP_MEMORY_TIMEOUT;
            halted              <= 1'b1;
            fetch_pending       <= 1'b0;
            memory_write_enable <= 1'b0;
            timeout_count       <= '0;
        end else begin
            case (state)
                FETCH_REQUEST: begin
                    if (memory_request_valid) begin
                        if (memory_request_ready) begin
                            state         <= FETCH_WAIT;
                            fetch_pending <= 1'b0;
                            timeout_count <= '0;
                        end else begin
                            fetch_pending <= 1'b1;
                            address_q     <= memory_address;
                            timeout_count <= timeout_count + 1'b1;
                        end
                    end
                end
                FETCH_WAIT: begin
                    if (memory_response_valid) begin
                        instruction   <= memory_read_data;
                        state         <= EXECUTE;
                        timeout_count <= '0;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                EXECUTE: begin
                    if (!instruction_valid) begin
                        state  <= HALTED;
                        trap_q <= TRAP_ILLEGAL_INSTRUCTION;
                        halted <= 1'b1;
                    end else if (memory_access && align_misaligned) begin
                        state  <= HALTED;
                        trap_q <= TRAP_MISALIGNED_ACCESS;
                        halted <= 1'b1;
                    end else if (memory_access) begin
                        address_q           <= word_align(data_address);
                        memory_write_enable <= decoded_memory_write;
                        memory_byte_enable  <= align_byte_enable;
                        memory_write_data   <= align_write_data;
                        size_q              <= align_size;
                        offset_q            <= data_address[1:0];
                        unsigned_q          <= load_unsigned;
                        state               <= MEMORY_REQUEST;
                    end else begin
                        state <= FETCH_REQUEST;
                    end
                end
                MEMORY_REQUEST: begin
                    if (memory_request_ready) begin
                        state         <= MEMORY_WAIT;
                        timeout_count <= '0;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                MEMORY_WAIT: begin
                    if (memory_response_valid) begin
                        timeout_count <= '0;
                        if (memory_write_enable) begin
                            memory_write_enable <= 1'b0;
                            state               <= FETCH_REQUEST;
                        end else begin
                            load_data <= align_load_value;
                            state     <= WRITEBACK;
                        end
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                WRITEBACK: state <= FETCH_REQUEST;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the tiny RISC-V core. It shares one memory port between instruction fetch and load/store, and sequences each instruction through the datapath: fetch, execute, memory, writeback. It gates register-file and PC writes, and aligns and extends load and store data. It sits between the instruction decoder and datapath on one side and the external memory port on the other.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles a memory transaction may remain unaccepted or unanswered before trapping; 0 disables the timeout.

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high reset
run_enable  input  1  permits starting a new fetch
program_counter  input  32  current PC from datapath
instruction_valid  input  1  decoder reports a legal operation (operation != invalid)
decoded_register_write_enable  input  1  from decoder control
decoded_memory_read  input  1  instruction is a load
decoded_memory_write  input  1  instruction is a store
memory_size  input  2  0 byte, 1 halfword, 2 word (funct3[1:0])
load_unsigned  input  1  funct3[2] of a load
data_address  input  32  ALU result (effective address)
store_data  input  32  rs2 value
memory_request_valid  output  1  request on memory port
memory_request_ready  input  1  memory accepts request
memory_address  output  32  request address, word-aligned (low 2 bits 0)
memory_write_enable  output  1  request is a write
memory_byte_enable  output  4  byte lanes for writes
memory_write_data  output  32  lane-shifted store data
memory_response_valid  input  1  read data / write acknowledge
memory_read_data  input  32  read data
instruction  output  32  instruction register
load_data  output  32  aligned, extended load result
register_write_strobe  output  1  one-cycle register-file write enable
pc_update_enable  output  1  one-cycle PC advance / branch commit
halted  output  1  core stopped on trap
trap_cause  output  2  0 none, 1 illegal, 2 misaligned, 3 timeout

Behaviour:
- Reset values: state FETCH_REQUEST. memory_request_valid, memory_write_enable, register_write_strobe, pc_update_enable and halted are 0. instruction, load_data, memory_address, memory_write_data and memory_byte_enable are 0. trap_cause is 0. Timeout counter is 0.
- States and transitions:
  - FETCH_REQUEST: valid = run_enable; address = {program_counter[31:2], 2'b00}; write_enable 0. On valid && ready, go to FETCH_WAIT.
  - FETCH_WAIT: on response_valid, instruction <= read_data, then go to EXECUTE.
  - EXECUTE: one cycle; decoder inputs are valid.
    - If !instruction_valid: go to HALTED, cause 1.
    - Else if read or write is misaligned (halfword with address[0] set, or word with address[1:0] != 0): go to HALTED, cause 2.
    - Else if load or store: latch address, byte enable and shifted data into the request registers, then go to MEMORY_REQUEST.
    - Else: register_write_strobe = decoded_register_write_enable, pc_update_enable = 1, then go to FETCH_REQUEST.
  - MEMORY_REQUEST: valid = 1; write_enable = decoded_memory_write. On ready, go to MEMORY_WAIT.
  - MEMORY_WAIT: on response_valid:
    - Store: pc_update_enable = 1, go to FETCH_REQUEST.
    - Load: load_data <= aligned and extended read_data, go to WRITEBACK.
  - WRITEBACK: register_write_strobe = 1, pc_update_enable = 1, go to FETCH_REQUEST.
  - HALTED: halted = 1; all strobes and valid are 0. Exits only on reset.
- Strobe outputs are combinational from state; every other output is registered.
- Handshake:
  - Once memory_request_valid is high, it and all request fields stay stable until ready. run_enable deassertion does not withdraw a request already presented.
  - One transaction outstanding.
  - Response is accepted no earlier than the cycle after acceptance; response_valid outside the WAIT states is ignored.
- Latency with zero-wait memory (ready = 1, response the next cycle):
  - ALU or branch instruction: 3 cycles.
  - Store: 5 cycles.
  - Load: 6 cycles.
- Byte enables:
  - Byte: 1 << address[1:0].
  - Halfword: 0011 << address[1:0].
  - Word: 1111.
  - Write data is replicated or shifted onto the lanes (byte into all 4 lanes, halfword into both halves).
- Load extraction: select the lane by address[1:0]. Zero-extend when load_unsigned, otherwise sign-extend. memory_size 3 is treated as word.
- Timeout:
  - The counter increments every cycle in FETCH_REQUEST (valid high), FETCH_WAIT, MEMORY_REQUEST or MEMORY_WAIT, and clears on every state change.
  - When it reaches TIMEOUT_CYCLES (nonzero), go to HALTED with cause 3.
  - Timeout takes priority over a response arriving in the same cycle.
- Reset mid-transaction: abandon the transaction, return to FETCH_REQUEST; no strobes fire.

Decomposition:
- Shared core types package: sequencer_state_t enum; trap_cause_t (None, Illegal_Instruction, Misaligned_Access, Memory_Timeout); memory_size_t (Byte, Halfword, Word).
- Sub-module load_store_aligner, combinational. It computes byte enable, shifted store data, load extraction/extension and the misaligned flag.

Test Plan:
- Zero-wait memory, fetch of addi x1,x0,5 at PC 0x0 → request at 0x0; register_write_strobe and pc_update_enable each pulse once, in cycle 2.
- ready held low 3 cycles during fetch → address and valid stable throughout; acceptance in cycle 3; no strobe before response.
- sb to address 0x103, store_data 0xAB → byte_enable 1000, write_data 0xABABABAB, address 0x100; after acknowledge, pc_update_enable pulses and register_write_strobe stays 0.
- lb from 0x102 with read_data 0x00F00000 → load_data 0xFFFFFFF0; lbu from the same address → 0x000000F0; strobe in WRITEBACK.
- instruction_valid = 0 in EXECUTE → halted = 1, trap_cause 1, memory_request_valid stays 0; lw from 0x102 → trap_cause 2.
- TIMEOUT_CYCLES = 4, response never arrives → halted with cause 3 after 4 wait cycles; reset pulse → back to FETCH_REQUEST with all outputs at reset values.
